// File: rtl/ucsbece154_mem_pkg.sv
// Shared definitions for the two-port SDRAM read arbiter: FSM state encoding,
// requester port IDs and the default burst length.
package ucsbece154_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic PORT_I = 1'b0;  // icache demand refill
    localparam logic PORT_P = 1'b1;  // icache prefetcher / dcache

    localparam int DEFAULT_BLOCK_WORDS = 4;

endpackage

// File: rtl/ucsbece154_rr_picker.sv
// Combinational two-way pick: fixed priority (port 0 wins ties) or round-robin
// (on a tie the port that did not win last time is chosen).
module ucsbece154_rr_picker
    import ucsbece154_mem_pkg::*;
#(
    parameter int RR_MODE = 0
) (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       winner,
    output logic       any_req
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        any_req = |req;
        winner  = PORT_I;
        if (req[1] && !req[0]) begin
            winner = PORT_P;
        end else if (req[1] && req[0] && (RR_MODE != 0)) begin
            winner = ~rr_last;
        end
    end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// Two-port block read arbiter in front of the SDRAM controller read channel.
// One uninterruptible BLOCK_WORDS burst at a time; an aborting owner's words are drained silently.
module ucsbece154_mem_arbiter
    import ucsbece154_mem_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int RR_MODE     = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req0,
    input  logic [31:0] Addr0,
    input  logic        Abort0,
    output logic        Grant0,
    output logic        Valid0,
    output logic        Done0,
    input  logic        Req1,
    input  logic [31:0] Addr1,
    input  logic        Abort1,
    output logic        Grant1,
    output logic        Valid1,
    output logic        Done1,
    output logic [31:0] RdData,
    output logic        Busy,
    output logic        Owner,
    output logic [31:0] MemReadAddress,
    output logic        MemReadRequest,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);

    localparam int CW = $clog2(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] word_cnt;
    logic          aborted;
    logic          rr_last;
    logic          winner;
    logic          any_req;
    logic          owner_abort;
    logic          deliver;
    logic          last_word;
    logic          word_ok;

    ucsbece154_rr_picker #(
        .RR_MODE(RR_MODE)
    ) u_picker (
        .req     ({Req1, Req0}),
        .rr_last (rr_last),
        .winner  (winner),
        .any_req (any_req)
    );

    assign owner_abort = (Owner == PORT_P) ? Abort1 : Abort0;
    assign deliver     = (state == BURST) && MemDataReady;
    assign last_word   = deliver && (word_cnt == LAST_WORD);
    // The word carrying the owner's abort is already suppressed, not just later ones.
    assign word_ok     = deliver && !aborted && !owner_abort;

    assign Valid0 = word_ok && (Owner == PORT_I);
    assign Valid1 = word_ok && (Owner == PORT_P);
    assign Done0  = Valid0 && last_word;
    assign Done1  = Valid1 && last_word;
    assign RdData = MemDataIn;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req)   state_next = BURST;
            BURST:   if (last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= IDLE;
            word_cnt       <= '0;
            aborted        <= 1'b0;
            rr_last        <= PORT_I;
            Owner          <= PORT_I;
            Grant0         <= 1'b0;
            Grant1         <= 1'b0;
            Busy           <= 1'b0;
            MemReadRequest <= 1'b0;
            MemReadAddress <= '0;
        end else begin
            state  <= state_next;
            Grant0 <= 1'b0;
            Grant1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        MemReadAddress <= (winner == PORT_P) ? Addr1 : Addr0;
                        MemReadRequest <= 1'b1;
                        Busy           <= 1'b1;
                        Grant0         <= (winner == PORT_I);
                        Grant1         <= (winner == PORT_P);
                        Owner          <= winner;
                        rr_last        <= winner;
                        word_cnt       <= '0;
                        aborted        <= 1'b0;
                    end
                end
                BURST: begin
                    if (owner_abort) aborted <= 1'b1;
                    // Power-of-two length: the counter wraps to 0 on the last word.
                    if (deliver) word_cnt <= word_cnt + 1'b1;
                    if (last_word) begin
                        MemReadRequest <= 1'b0;
                        Busy           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Scoreboard bench: two arbiters (fixed priority and round-robin) under random
// requesters and a random-latency memory, checked against a burst-level model.
module tb_ucsbece154_mem_arbiter;

    localparam int BW = 4;

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
        bit          done;
    } word_t;

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] addr;
    } grant_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [1:0]  req0, req1, abort0, abort1, mem_ready;
    logic [31:0] addr0 [2];
    logic [31:0] addr1 [2];
    logic [31:0] mem_data [2];
    logic [1:0]  grant0, grant1, valid0, valid1, done0, done1, busy, owner, mem_req;
    logic [31:0] rd_data [2];
    logic [31:0] mem_addr [2];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ucsbece154_mem_arbiter #(
            .BLOCK_WORDS (BW),
            .RR_MODE     (g)
        ) dut (
            .Clk            (Clk),
            .Reset_n        (Reset_n),
            .Req0           (req0[g]),
            .Addr0          (addr0[g]),
            .Abort0         (abort0[g]),
            .Grant0         (grant0[g]),
            .Valid0         (valid0[g]),
            .Done0          (done0[g]),
            .Req1           (req1[g]),
            .Addr1          (addr1[g]),
            .Abort1         (abort1[g]),
            .Grant1         (grant1[g]),
            .Valid1         (valid1[g]),
            .Done1          (done1[g]),
            .RdData         (rd_data[g]),
            .Busy           (busy[g]),
            .Owner          (owner[g]),
            .MemReadAddress (mem_addr[g]),
            .MemReadRequest (mem_req[g]),
            .MemDataIn      (mem_data[g]),
            .MemDataReady   (mem_ready[g])
        );
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit in_reset = 1'b1;

    word_t  wq [2][$];
    grant_t gq [2][$];

    // Model: one outstanding burst per arbiter, counted down in words.
    bit exp_busy  [2];
    bit m_busy    [2];
    int m_owner   [2];
    int m_left    [2];
    bit m_discard [2];
    int m_last    [2];
    // Requester per (dut, port): 0 idle, 1 requesting, 2 drop after grant.
    int rs [2][2];

    task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, m, cyc, act, exp);
        end
    endtask

    task automatic report(input string name, input int m, input string detail);
        checks++;
        failures++;
        $display("FAIL %s dut%0d cycle %0d: %s", name, m, cyc, detail);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            exp_busy[m]  = 1'b0;
            m_busy[m]    = 1'b0;
            m_owner[m]   = 0;
            m_left[m]    = 0;
            m_discard[m] = 1'b0;
            m_last[m]    = 0;
            rs[m][0]     = 0;
            rs[m][1]     = 0;
            wq[m].delete();
            gq[m].delete();
        end
    endtask

    task automatic set_req(input int m, input int p, input logic v);
        if (p == 0) req0[m] = v;
        else        req1[m] = v;
    endtask

    task automatic drive_and_model(input int m, input bit allow_new);
        logic r [2];
        bit   oa;
        int   w;
        for (int p = 0; p < 2; p++) begin
            case (rs[m][p])
                0: if (allow_new && $urandom_range(0, 2) == 0) begin
                    rs[m][p] = 1;
                    set_req(m, p, 1'b1);
                    if (p == 0) addr0[m] = $urandom;
                    else        addr1[m] = $urandom;
                end
                1: if (!allow_new || $urandom_range(0, 23) == 0) begin
                    rs[m][p] = 0;
                    set_req(m, p, 1'b0);
                end
                default: begin
                    rs[m][p] = 0;
                    set_req(m, p, 1'b0);
                end
            endcase
        end
        abort0[m]    = ($urandom_range(0, 15) == 0);
        abort1[m]    = ($urandom_range(0, 15) == 0);
        mem_ready[m] = m_busy[m] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
        mem_data[m]  = $urandom;

        exp_busy[m] = m_busy[m];
        if (m_busy[m]) begin
            oa = (m_owner[m] == 0) ? abort0[m] : abort1[m];
            if (mem_ready[m]) begin
                if (!m_discard[m] && !oa)
                    wq[m].push_back('{cyc: cyc, port: m_owner[m], data: mem_data[m], done: (m_left[m] == 1)});
                m_left[m]--;
            end
            if (oa) m_discard[m] = 1'b1;
            if (m_left[m] == 0) m_busy[m] = 1'b0;
        end else begin
            r[0] = req0[m];
            r[1] = req1[m];
            if (r[0] || r[1]) begin
                if (r[0] && r[1]) w = (m == 1) ? 1 - m_last[m] : 0;
                else              w = r[1] ? 1 : 0;
                gq[m].push_back('{cyc: cyc + 1, port: w, addr: (w == 0) ? addr0[m] : addr1[m]});
                m_busy[m]    = 1'b1;
                m_owner[m]   = w;
                m_left[m]    = BW;
                m_discard[m] = 1'b0;
                m_last[m]    = w;
                rs[m][w]     = $urandom_range(0, 1) ? 1 : 2;
            end
        end
    endtask

    task automatic step(input bit allow_new);
        @(negedge Clk);
        cyc++;
        for (int m = 0; m < 2; m++) drive_and_model(m, allow_new);
    endtask

    task automatic quiet_inputs(input bit stray);
        for (int m = 0; m < 2; m++) begin
            req0[m]      = 1'b0;
            req1[m]      = 1'b0;
            abort0[m]    = 1'b0;
            abort1[m]    = 1'b0;
            mem_ready[m] = stray ? $urandom_range(0, 1) : 1'b0;
            mem_data[m]  = $urandom;
        end
    endtask

    task automatic monitor_dut(input int m);
        word_t  w;
        grant_t g;
        logic   v [2];
        logic   d [2];
        if (in_reset) begin
            check("reset_quiet", m, 32'({grant0[m], grant1[m], valid0[m], valid1[m],
                                         done0[m], done1[m], busy[m], mem_req[m]}), 32'd0);
            return;
        end
        check("busy", m, 32'(busy[m]), 32'(exp_busy[m]));
        check("mem_req", m, 32'(mem_req[m]), 32'(exp_busy[m]));

        if (grant0[m] || grant1[m]) begin
            if (grant0[m] && grant1[m]) report("double_grant", m, "got both grants expected one");
            if (gq[m].size() == 0) begin
                report("spurious_grant", m, "got grant expected none");
            end else begin
                g = gq[m].pop_front();
                check("grant_cycle", m, cyc, g.cyc);
                check("grant_port", m, 32'(grant1[m]), g.port);
                check("grant_owner", m, 32'(owner[m]), g.port);
                check("grant_addr", m, mem_addr[m], g.addr);
            end
        end else if (gq[m].size() != 0 && gq[m][0].cyc <= cyc) begin
            void'(gq[m].pop_front());
            report("missing_grant", m, "got no grant expected one");
        end

        v[0] = valid0[m]; v[1] = valid1[m];
        d[0] = done0[m];  d[1] = done1[m];
        for (int p = 0; p < 2; p++) begin
            if (v[p]) begin
                if (wq[m].size() == 0) begin
                    report("spurious_valid", m, $sformatf("got valid%0d expected none", p));
                end else begin
                    w = wq[m].pop_front();
                    check("word_cycle", m, cyc, w.cyc);
                    check("word_port", m, p, w.port);
                    check("word_data", m, rd_data[m], w.data);
                    check("word_done", m, 32'(d[p]), 32'(w.done));
                end
            end else if (d[p]) begin
                report("done_without_valid", m, $sformatf("got done%0d expected none", p));
            end
        end
        while (wq[m].size() != 0 && wq[m][0].cyc <= cyc) begin
            w = wq[m].pop_front();
            report("missing_word", m, $sformatf("got no valid expected word %0h on port %0d", w.data, w.port));
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            #3;
            for (int m = 0; m < 2; m++) monitor_dut(m);
        end
    end

    initial begin
        int guard;
        Reset_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            addr0[m] = '0;
            addr1[m] = '0;
        end
        quiet_inputs(1'b0);
        model_reset();
        repeat (3) begin
            @(negedge Clk);
            cyc++;
            quiet_inputs(1'b1);
        end
        @(negedge Clk);
        cyc++;
        quiet_inputs(1'b0);
        in_reset = 1'b0;
        Reset_n  = 1'b1;

        repeat (1500) step(1'b1);

        // Reset in the middle of a burst on both arbiters.
        guard = 0;
        while (!(m_busy[0] && m_busy[1] && m_left[0] < BW && m_left[1] < BW) && guard < 300) begin
            step(1'b1);
            guard++;
        end
        if (guard >= 300) report("mid_burst_setup", 0, "got no overlapping bursts expected one within 300 cycles");
        @(negedge Clk);
        cyc++;
        Reset_n  = 1'b0;
        in_reset = 1'b1;
        quiet_inputs(1'b0);
        #1;
        for (int m = 0; m < 2; m++) begin
            check("async_reset_req", m, 32'(mem_req[m]), 32'd0);
            check("async_reset_busy", m, 32'(busy[m]), 32'd0);
        end
        model_reset();
        repeat (3) begin
            @(negedge Clk);
            cyc++;
            quiet_inputs(1'b1);
        end
        @(negedge Clk);
        cyc++;
        quiet_inputs(1'b1);
        in_reset = 1'b0;
        Reset_n  = 1'b1;
        // Stray data strobes in IDLE after reset must produce no Valid.
        repeat (6) begin
            @(negedge Clk);
            cyc++;
            quiet_inputs(1'b1);
        end

        repeat (1500) step(1'b1);

        guard = 0;
        while ((m_busy[0] || m_busy[1] || wq[0].size() != 0 || wq[1].size() != 0 ||
                gq[0].size() != 0 || gq[1].size() != 0) && guard < 300) begin
            step(1'b0);
            guard++;
        end
        repeat (3) step(1'b0);
        for (int m = 0; m < 2; m++) begin
            check("drain_words", m, wq[m].size(), 32'd0);
            check("drain_grants", m, gq[m].size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
